// File: rtl/approx_err_pkg.sv
// Shared constants and FSM encoding for the approximate-multiplier error monitor.
package approx_err_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCUM  = 2'd1;
  localparam state_t DRAIN  = 2'd2;
  localparam state_t REPORT = 2'd3;

endpackage

// File: rtl/approx_err_pipe.sv
// S1/S2 datapath: exact product, then |approx_y - exact| with the operands carried along.
// Two-cycle latency. It never stalls, so the downstream accumulators must consume every cycle.
module approx_err_pipe
  import approx_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_fire,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] approx_y,
  output logic              s1_vld,
  output logic              s2_vld,
  output logic [PROD_W-1:0] d,
  output logic [OP_W-1:0]   d_a,
  output logic [OP_W-1:0]   d_b
);

  logic [PROD_W-1:0] s1_exact;
  logic [PROD_W-1:0] s1_approx;
  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic [PROD_W:0]   diff;
  logic [PROD_W-1:0] mag;

  // The exact product never reaches 2^64, so a negative difference always fits in 64 magnitude bits.
  assign diff = {1'b0, s1_approx} - {1'b0, s1_exact};
  assign mag  = diff[PROD_W] ? (~diff[PROD_W-1:0] + 64'd1) : diff[PROD_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= in_fire;
      s2_vld <= s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_exact  <= PROD_W'(a) * PROD_W'(b);
      s1_approx <= approx_y;
      s1_a      <= a;
      s1_b      <= b;
    end
    if (s1_vld) begin
      d   <= mag;
      d_a <= s1_a;
      d_b <= s1_b;
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics (count, saturating sum, max with operands) for an approximate multiplier.
// Report appears 3 cycles after the last sample. It is held until rpt_ready, and no input is accepted meanwhile.
module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int WINDOW = 1024,
  parameter int CNT_W  = 32,
  parameter int SUM_W  = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] approx_y,
  output logic              busy,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CNT_W-1:0]  err_count,
  output logic [SUM_W-1:0]  err_sum,
  output logic [PROD_W-1:0] err_max,
  output logic [OP_W-1:0]   err_max_a,
  output logic [OP_W-1:0]   err_max_b,
  output logic [CNT_W-1:0]  sample_count
);

  state_t            state;
  logic              in_fire;
  logic              last_smp;
  logic              s1_vld;
  logic              s2_vld;
  logic [PROD_W-1:0] d;
  logic [OP_W-1:0]   d_a;
  logic [OP_W-1:0]   d_b;
  logic [SUM_W:0]    sum_ext;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign rpt_valid = (state == REPORT);
  assign in_fire   = in_valid & in_ready;
  assign last_smp  = in_fire && (sample_count == CNT_W'(WINDOW - 1));
  assign sum_ext   = {1'b0, err_sum} + (SUM_W + 1)'(d);

  approx_err_pipe u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_fire  (in_fire),
    .a        (a),
    .b        (b),
    .approx_y (approx_y),
    .s1_vld   (s1_vld),
    .s2_vld   (s2_vld),
    .d        (d),
    .d_a      (d_a),
    .d_b      (d_b)
  );

  // DRAIN exits once S1 is empty; the final S2 sample lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= ACCUM;
        ACCUM:   if (last_smp) state <= DRAIN;
        DRAIN:   if (!s1_vld) state <= REPORT;
        REPORT:  if (rpt_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE && start)) begin
      err_count    <= '0;
      err_sum      <= '0;
      err_max      <= '0;
      err_max_a    <= '0;
      err_max_b    <= '0;
      sample_count <= '0;
    end else begin
      if (in_fire) sample_count <= sample_count + 1'b1;
      if (s2_vld) begin
        err_count <= err_count + CNT_W'(d != '0);
        err_sum   <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        // Strict compare keeps the first sample on ties.
        if (d > err_max) begin
          err_max   <= d;
          err_max_a <= d_a;
          err_max_b <= d_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench: four monitor instances cover the window sizes and sum widths exercised below.
module tb_approx_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  start = '0;
  logic        in_valid = 1'b0;
  logic        rpt_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] approx_y = '0;

  logic        in_ready_o[4];
  logic        busy_o[4];
  logic        rpt_valid_o[4];
  logic [31:0] cnt_o[4];
  logic [79:0] sum_o[4];
  logic [63:0] mx_o[4];
  logic [31:0] ma_o[4];
  logic [31:0] mb_o[4];
  logic [31:0] sc_o[4];
  logic [63:0] sum3;

  int cyc = 0;
  int last_t = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          inst;
    logic [31:0] cnt;
    logic [79:0] sum;
    logic [63:0] mx;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] sc;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  approx_err_monitor #(.WINDOW(4), .CNT_W(32), .SUM_W(80)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .approx_y(approx_y), .busy(busy_o[0]), .rpt_valid(rpt_valid_o[0]),
    .rpt_ready(rpt_ready), .err_count(cnt_o[0]), .err_sum(sum_o[0]), .err_max(mx_o[0]),
    .err_max_a(ma_o[0]), .err_max_b(mb_o[0]), .sample_count(sc_o[0]));

  approx_err_monitor #(.WINDOW(3), .CNT_W(32), .SUM_W(80)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .approx_y(approx_y), .busy(busy_o[1]), .rpt_valid(rpt_valid_o[1]),
    .rpt_ready(rpt_ready), .err_count(cnt_o[1]), .err_sum(sum_o[1]), .err_max(mx_o[1]),
    .err_max_a(ma_o[1]), .err_max_b(mb_o[1]), .sample_count(sc_o[1]));

  approx_err_monitor #(.WINDOW(2), .CNT_W(32), .SUM_W(80)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_ready(in_ready_o[2]),
    .a(a), .b(b), .approx_y(approx_y), .busy(busy_o[2]), .rpt_valid(rpt_valid_o[2]),
    .rpt_ready(rpt_ready), .err_count(cnt_o[2]), .err_sum(sum_o[2]), .err_max(mx_o[2]),
    .err_max_a(ma_o[2]), .err_max_b(mb_o[2]), .sample_count(sc_o[2]));

  approx_err_monitor #(.WINDOW(2), .CNT_W(32), .SUM_W(64)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .in_valid(in_valid), .in_ready(in_ready_o[3]),
    .a(a), .b(b), .approx_y(approx_y), .busy(busy_o[3]), .rpt_valid(rpt_valid_o[3]),
    .rpt_ready(rpt_ready), .err_count(cnt_o[3]), .err_sum(sum3), .err_max(mx_o[3]),
    .err_max_a(ma_o[3]), .err_max_b(mb_o[3]), .sample_count(sc_o[3]));

  assign sum_o[3] = {16'h0, sum3};

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each new report and checks stability while it is held.
  initial begin : monitor
    logic        pv[4];
    exp_t        e;
    exp_t        snap[4];
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rpt_valid_o[i] === 1'b1 && !pv[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_report inst%0d: report with empty scoreboard", i);
          end else begin
            e = sb.pop_front();
            chk($sformatf("rpt_inst%0d", i), 80'(i), 80'(e.inst));
            chk($sformatf("err_count%0d", i), 80'(cnt_o[i]), 80'(e.cnt));
            chk($sformatf("err_sum%0d", i), sum_o[i], e.sum);
            chk($sformatf("err_max%0d", i), 80'(mx_o[i]), 80'(e.mx));
            chk($sformatf("err_max_a%0d", i), 80'(ma_o[i]), 80'(e.ma));
            chk($sformatf("err_max_b%0d", i), 80'(mb_o[i]), 80'(e.mb));
            chk($sformatf("sample_count%0d", i), 80'(sc_o[i]), 80'(e.sc));
            chk($sformatf("rpt_cycle%0d", i), 80'(cyc), 80'(e.cyc));
            snap[i] = '{i, cnt_o[i], sum_o[i], mx_o[i], ma_o[i], mb_o[i], sc_o[i], cyc};
          end
        end else if (rpt_valid_o[i] === 1'b1 && pv[i]) begin
          chk($sformatf("hold_cnt%0d", i), 80'(cnt_o[i]), 80'(snap[i].cnt));
          chk($sformatf("hold_sum%0d", i), sum_o[i], snap[i].sum);
          chk($sformatf("hold_max%0d", i), 80'(mx_o[i]), 80'(snap[i].mx));
          chk($sformatf("hold_sc%0d", i), 80'(sc_o[i]), 80'(snap[i].sc));
          chk($sformatf("hold_in_ready%0d", i), 80'(in_ready_o[i]), 80'd0);
        end
        pv[i] = (rpt_valid_o[i] === 1'b1);
      end
    end
  end

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_busy"}, 80'(busy_o[i]), 80'd0);
    chk({tag, "_rpt_valid"}, 80'(rpt_valid_o[i]), 80'd0);
    chk({tag, "_in_ready"}, 80'(in_ready_o[i]), 80'd0);
    chk({tag, "_cnt"}, 80'(cnt_o[i]), 80'd0);
    chk({tag, "_sum"}, sum_o[i], 80'd0);
    chk({tag, "_max"}, 80'(mx_o[i]), 80'd0);
    chk({tag, "_max_ab"}, 80'({ma_o[i], mb_o[i]}), 80'd0);
    chk({tag, "_sc"}, 80'(sc_o[i]), 80'd0);
  endtask

  task automatic do_start(input int i);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    chk($sformatf("start_lat%0d", i), 80'(in_ready_o[i]), 80'd1);
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] ty);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    approx_y = ty;
    last_t = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input int i, input logic [31:0] cnt, input logic [79:0] sum,
                          input logic [63:0] mx, input logic [31:0] ma, input logic [31:0] mb,
                          input logic [31:0] sc);
    exp_t e;
    e = '{i, cnt, sum, mx, ma, mb, sc, last_t + 3};
    sb.push_back(e);
    chk($sformatf("in_ready_drop%0d", i), 80'(in_ready_o[i]), 80'd0);
  endtask

  task automatic wait_rpt(input int i);
    int n = 0;
    while (rpt_valid_o[i] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (rpt_valid_o[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rpt_timeout inst%0d: rpt_valid=0 required 1", i);
    end
  endtask

  task automatic handshake(input int i);
    rpt_ready = 1'b1;
    @(posedge clk); #1;
    rpt_ready = 1'b0;
    chk($sformatf("post_hs_busy%0d", i), 80'(busy_o[i]), 80'd0);
    chk($sformatf("post_hs_rpt_valid%0d", i), 80'(rpt_valid_o[i]), 80'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) chk_idle(i, $sformatf("reset%0d", i));

    // Exact window
    do_start(0);
    drive(32'd3, 32'd7, 64'd21);
    drive(32'd100, 32'd200, 64'd20000);
    drive(32'hFFFFFFFF, 32'd2, 64'h1_FFFF_FFFE);
    drive(32'h12345678, 32'h10, 64'h1_2345_6780);
    push_exp(0, 0, 0, 0, 0, 0, 4);
    wait_rpt(0);
    handshake(0);

    // Single low error on the largest operands
    do_start(0);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFD_FFFF_FFF1);
    drive(32'd1, 32'd1, 64'd1);
    drive(32'd2, 32'd2, 64'd4);
    drive(32'd0, 32'd5, 64'd0);
    push_exp(0, 1, 80'h10, 64'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);
    wait_rpt(0);
    handshake(0);

    // Both signs and a tie on the maximum
    do_start(1);
    drive(32'd2, 32'd3, 64'd9);
    drive(32'd4, 32'd5, 64'd15);
    drive(32'd5, 32'd5, 64'd30);
    push_exp(1, 3, 80'd13, 64'd5, 32'd4, 32'd5, 3);
    wait_rpt(1);
    handshake(1);

    // Gapped input, held report, start pulses during REPORT
    do_start(2);
    drive(32'd6, 32'd7, 64'd40);
    @(posedge clk);
    @(posedge clk); #1;
    drive(32'd10, 32'd10, 64'd100);
    push_exp(2, 1, 80'd2, 64'd2, 32'd6, 32'd7, 2);
    wait_rpt(2);
    for (int k = 0; k < 5; k++) begin
      start[2] = (k == 2);
      in_valid = 1'b1;
      a = 32'd9; b = 32'd9; approx_y = 64'd0;
      @(posedge clk); #1;
      start[2] = 1'b0;
      in_valid = 1'b0;
      chk($sformatf("bp_busy_k%0d", k), 80'(busy_o[2]), 80'd1);
    end
    start[2] = 1'b1;
    handshake(2);
    start[2] = 1'b0;
    chk("bp_post_in_ready", 80'(in_ready_o[2]), 80'd0);
    @(posedge clk); #1;
    chk("bp_start_ignored", 80'(busy_o[2]), 80'd0);

    // Reset mid-window
    do_start(0);
    drive(32'd3, 32'd3, 64'd10);
    drive(32'd4, 32'd4, 64'd17);
    chk("mid_sc", 80'(sc_o[0]), 80'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle(0, "midrst");
    do_start(0);
    drive(32'd11, 32'd11, 64'd121);
    drive(32'd0, 32'd0, 64'd0);
    drive(32'd7, 32'd8, 64'd56);
    drive(32'h10000, 32'h10000, 64'h1_0000_0000);
    push_exp(0, 0, 0, 0, 0, 0, 4);
    wait_rpt(0);
    handshake(0);

    // Saturation on a 64-bit sum
    do_start(3);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
    push_exp(3, 2, 80'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    wait_rpt(3);
    handshake(3);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 80'(sb.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-metric stage that sits directly downstream of `approx_32x32`. It consumes the operands and the approximate 64-bit product and computes the exact product internally. Over a window of `WINDOW` samples it accumulates error count, sum of absolute error and maximum absolute error, then presents one report through a valid/ready handshake. The team uses it for on-silicon and in-simulation characterisation of the approximate multipliers.

## Interface
- `WINDOW`, 1024: samples per report; 1 ≤ WINDOW ≤ 2^CNT_W−1.
- `CNT_W`, 32: width of `err_count` and `sample_count`.
- `SUM_W`, 80: width of `err_sum`; ≥64.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: pulse; begins a window, honoured only in IDLE.
- `in_valid` in 1: `a`, `b` and `approx_y` are valid.
- `in_ready` out 1: sample accepted when `in_valid & in_ready`.
- `a`, `b` in 32 each: unsigned operands.
- `approx_y` in 64: approximate product for `a`, `b`.
- `busy` out 1: high in any state other than IDLE.
- `rpt_valid` out 1: report outputs are valid.
- `rpt_ready` in 1: consumer takes the report.
- `err_count` out CNT_W: samples with approx_y ≠ a·b.
- `err_sum` out SUM_W: Σ|approx_y − a·b|, saturating.
- `err_max` out 64: largest |approx_y − a·b|.
- `err_max_a`, `err_max_b` out 32 each: operands of the first sample reaching `err_max`.
- `sample_count` out CNT_W: samples accepted in the current window.

## Operation
- FSM states:
  - IDLE: in `start` → ACCUM; clears all accumulators and `sample_count`.
  - ACCUM: `in_ready`=1. Each accepted sample increments `sample_count`. When the WINDOW-th sample is accepted → DRAIN, and `in_ready` drops in the next cycle.
  - DRAIN: waits until the pipeline is empty → REPORT.
  - REPORT: `rpt_valid`=1. Outputs are held stable until `rpt_ready` → IDLE.
- `start` outside IDLE is ignored, including a cycle where the REPORT handshake completes.
- Per-sample pipeline:
  - S1 registers exact = a·b (64b), approx_y, a and b.
  - S2 registers d = |approx_y − exact|, computed as a 65-bit signed difference, then magnitude. Both signs count.
  - S3 updates the accumulators:
    - `err_count` += (d≠0).
    - `err_sum` += d, saturating at all-ones.
    - If d > `err_max`, `err_max`, `err_max_a` and `err_max_b` update. Strict compare, so ties keep the first sample.
- Accumulator outputs are live during ACCUM/DRAIN; they are only guaranteed final while `rpt_valid`.
- Reset values: all outputs 0, state IDLE, pipeline valid bits 0, `in_ready`=0.
- Reset mid-window discards all partial results and in-flight samples.

## Timing
- Input acceptance: 1 cycle per sample at full rate; no bubbles are required between samples.
- Sample accepted in cycle T:
  - S1 is loaded at the end of T.
  - S2 is loaded at the end of T+1.
  - Accumulators are updated at the end of T+2.
- Last sample accepted in cycle T: `rpt_valid` is first high in cycle T+3.
- `in_valid` gaps: the pipeline simply carries bubbles, with no effect on results.
- `rpt_valid` holds for any duration of `rpt_ready`=0. On the handshake cycle, state is IDLE and `rpt_valid`=0 next cycle.
- The `start` to first `in_ready` latency is 1 cycle.

## Structure
- Package `approx_err_pkg`:
  - state enum (IDLE, ACCUM, DRAIN, REPORT).
  - constants OP_W=32, PROD_W=64.
- Sub-module `approx_err_pipe`: the S1/S2 datapath (exact multiply, abs-difference, valid bits).
- The top holds the FSM, counters and S3 accumulators.
- The monitor does not instantiate the approximate multiplier; the bench wires `approx_32x32` into `approx_y`.

## Test plan
- **Exact window:** WINDOW=4, start, 4 back-to-back samples with approx_y = a·b → `err_count`=0, `err_sum`=0, `err_max`=0, `sample_count`=4, `rpt_valid` at T+3.
- **Single low error:** WINDOW=4, sample a=b=0xFFFFFFFF with approx_y = exact−0x10, other 3 exact → `err_count`=1, `err_sum`=0x10, `err_max`=0x10, `err_max_a`=`err_max_b`=0xFFFFFFFF.
- **Signs and ties:** WINDOW=3, samples:
  - (2,3,approx 9) → d=3.
  - (4,5,approx 15) → d=5.
  - (5,5,approx 30) → d=5.
  - Required report: `err_count`=3, `err_sum`=13, `err_max`=5, `err_max_a`=4, `err_max_b`=5.
- **Backpressure:** WINDOW=2 with `in_valid` gapped, `rpt_ready` held low 5 cycles, `start` pulsed during REPORT:
  - Outputs stay stable and `in_ready`=0.
  - `start` is ignored.
  - IDLE the cycle after the handshake.
- **Reset mid-window:** reset for 1 cycle after 2 of 4 samples → all outputs 0, IDLE. Then start plus 4 exact samples → report reflects only the new 4 (`sample_count`=4, `err_count`=0).
- **Saturation:** SUM_W=64, WINDOW=2, both samples a=b=0xFFFFFFFF with approx_y=0 → `err_sum`=0xFFFFFFFFFFFFFFFF, `err_max`=0xFFFFFFFE00000001.
